// File: rtl/cve2_pkg.sv
// Shared types for the CVE2 pipeline slice.
// Writeback queue entry layout and instruction class.
package cve2_pkg;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

    typedef struct packed {
        logic           valid;
        logic           done;
        wb_instr_type_e itype;
        logic           we;
        logic [4:0]     waddr;
        logic [31:0]    wdata;
        logic [31:0]    pc;
        logic           compressed;
        logic           count;
        logic           err;
    } wb_entry_t;

    function automatic logic is_lsu(wb_instr_type_e t);
        return t != WB_INSTR_OTHER;
    endfunction

endpackage

// File: rtl/cve2_wb_fwd_lookup.sv
// Youngest-writer search over the writeback queue for one read port.
// Walks oldest to youngest from head so the last match wins.
module cve2_wb_fwd_lookup #(
    parameter  int unsigned Depth = 2,
    localparam int unsigned PW    = $clog2(Depth)
) (
    input  logic [Depth-1:0]       valid,
    input  logic [Depth-1:0]       we,
    input  logic [Depth-1:0]       done,
    input  logic [Depth-1:0][4:0]  waddr,
    input  logic [Depth-1:0][31:0] wdata,
    input  logic [PW-1:0]          head,
    input  logic [4:0]             raddr,
    output logic                   fwd_valid,
    output logic [31:0]            fwd_data,
    output logic                   hazard
);

    logic          hit;
    logic          hit_done;
    logic [31:0]   hit_data;
    logic [PW-1:0] idx;

    always_comb begin
        hit      = 1'b0;
        hit_done = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int k = 0; k < Depth; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && we[idx] && waddr[idx] == raddr && raddr != 5'd0) begin
                hit      = 1'b1;
                hit_done = done[idx];
                hit_data = wdata[idx];
            end
        end
    end

    assign fwd_valid = hit & hit_done;
    assign fwd_data  = fwd_valid ? hit_data : '0;
    assign hazard    = hit & ~hit_done;

endmodule

// File: rtl/cve2_wb_queue.sv
// In-order multi-entry writeback queue with load capture,
// RF retire, forwarding and load-use hazard detection.
module cve2_wb_queue
    import cve2_pkg::*;
#(
    parameter  int unsigned Depth    = 2,
    parameter  bit          ResetAll = 1'b0,
    localparam int unsigned PW       = $clog2(Depth),
    localparam int unsigned CW       = PW + 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_wb_i,
    input  wb_instr_type_e instr_type_wb_i,
    input  logic [31:0]    pc_id_i,
    input  logic           instr_is_compressed_id_i,
    input  logic           instr_perf_count_id_i,
    input  logic [4:0]     rf_waddr_id_i,
    input  logic [31:0]    rf_wdata_id_i,
    input  logic           rf_we_id_i,
    output logic           ready_wb_o,
    input  logic           lsu_resp_valid_i,
    input  logic           lsu_resp_err_i,
    input  logic [31:0]    rf_wdata_lsu_i,
    input  logic [4:0]     rf_raddr_a_i,
    input  logic [4:0]     rf_raddr_b_i,
    output logic           fwd_a_valid_o,
    output logic           fwd_b_valid_o,
    output logic [31:0]    fwd_a_data_o,
    output logic [31:0]    fwd_b_data_o,
    output logic           hazard_a_o,
    output logic           hazard_b_o,
    output logic [4:0]     rf_waddr_wb_o,
    output logic [31:0]    rf_wdata_wb_o,
    output logic           rf_we_wb_o,
    output logic [31:0]    pc_wb_o,
    output logic           instr_done_wb_o,
    output logic           perf_instr_ret_wb_o,
    output logic           perf_instr_ret_compressed_wb_o,
    output logic           outstanding_load_wb_o,
    output logic           outstanding_store_wb_o,
    output logic [CW-1:0]  count_o
);

    wb_entry_t     q_q [Depth];
    wb_entry_t     q_d [Depth];
    wb_entry_t     eff [Depth];
    wb_entry_t     he;
    logic [PW-1:0] head_q, tail_q, lsu_ptr_q;
    logic [PW-1:0] head_d, tail_d, lsu_ptr_d, idx;
    logic          lsu_pend_q, lsu_pend_d;
    logic [CW-1:0] count_q;
    logic          resp, retire, full, enq;

    logic [Depth-1:0]       e_valid, e_we, e_done;
    logic [Depth-1:0][4:0]  e_waddr;
    logic [Depth-1:0][31:0] e_wdata;

    assign resp = lsu_resp_valid_i & lsu_pend_q;

    // Entry view with this cycle's LSU response already applied.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            eff[i] = q_q[i];
            if (resp && lsu_ptr_q == PW'(i)) begin
                eff[i].done = 1'b1;
                if (lsu_resp_err_i) begin
                    eff[i].err = 1'b1;
                    eff[i].we  = 1'b0;
                end else if (eff[i].itype == WB_INSTR_LOAD) begin
                    eff[i].wdata = rf_wdata_lsu_i;
                end
            end
        end
    end

    assign he         = eff[head_q];
    assign retire     = he.valid & he.done;
    assign full       = count_q == CW'(Depth);
    assign ready_wb_o = ~full | retire;
    assign enq        = en_wb_i & ready_wb_o;
    assign head_d     = head_q + PW'(retire);
    assign tail_d     = tail_q + PW'(enq);

    always_comb begin
        q_d = eff;
        if (retire) begin
            q_d[head_q].valid = 1'b0;
            q_d[head_q].done  = 1'b0;
        end
        if (enq) begin
            q_d[tail_q] = '{
                valid:      1'b1,
                done:       ~is_lsu(instr_type_wb_i),
                itype:      instr_type_wb_i,
                we:         rf_we_id_i,
                waddr:      rf_waddr_id_i,
                wdata:      rf_wdata_id_i,
                pc:         pc_id_i,
                compressed: instr_is_compressed_id_i,
                count:      instr_perf_count_id_i,
                err:        1'b0
            };
        end
    end

    // Oldest not-done LSU entry of the next state.
    always_comb begin
        lsu_pend_d = 1'b0;
        lsu_ptr_d  = tail_d;
        idx        = head_d;
        for (int k = Depth - 1; k >= 0; k--) begin
            idx = head_d + PW'(k);
            if (q_d[idx].valid && !q_d[idx].done && is_lsu(q_d[idx].itype)) begin
                lsu_pend_d = 1'b1;
                lsu_ptr_d  = idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            lsu_ptr_q  <= '0;
            lsu_pend_q <= 1'b0;
            count_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            lsu_ptr_q  <= lsu_ptr_d;
            lsu_pend_q <= lsu_pend_d;
            count_q    <= count_q + CW'(enq) - CW'(retire);
        end
    end

    if (ResetAll) begin : g_rst_all
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < Depth; i++) q_q[i] <= '0;
            end else begin
                q_q <= q_d;
            end
        end
    end else begin : g_rst_ctrl
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < Depth; i++) begin
                    q_q[i].valid <= 1'b0;
                    q_q[i].done  <= 1'b0;
                end
            end else begin
                q_q <= q_d;
            end
        end
    end

    always_comb begin
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            e_valid[i] = eff[i].valid;
            e_we[i]    = eff[i].we;
            e_done[i]  = eff[i].done;
            e_waddr[i] = eff[i].waddr;
            e_wdata[i] = eff[i].wdata;
            if (q_q[i].valid && q_q[i].itype == WB_INSTR_LOAD)
                outstanding_load_wb_o = 1'b1;
            if (q_q[i].valid && q_q[i].itype == WB_INSTR_STORE)
                outstanding_store_wb_o = 1'b1;
        end
    end

    assign rf_we_wb_o      = retire & he.we & ~he.err;
    assign rf_waddr_wb_o   = he.valid ? he.waddr : '0;
    assign rf_wdata_wb_o   = he.valid ? he.wdata : '0;
    assign pc_wb_o         = he.valid ? he.pc : '0;
    assign instr_done_wb_o = retire;
    assign perf_instr_ret_wb_o = retire & he.count & ~he.err;
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & he.compressed;
    assign count_o         = count_q;

    cve2_wb_fwd_lookup #(.Depth(Depth)) u_fwd_a (
        .valid(e_valid), .we(e_we), .done(e_done),
        .waddr(e_waddr), .wdata(e_wdata), .head(head_q),
        .raddr(rf_raddr_a_i), .fwd_valid(fwd_a_valid_o),
        .fwd_data(fwd_a_data_o), .hazard(hazard_a_o)
    );

    cve2_wb_fwd_lookup #(.Depth(Depth)) u_fwd_b (
        .valid(e_valid), .we(e_we), .done(e_done),
        .waddr(e_waddr), .wdata(e_wdata), .head(head_q),
        .raddr(rf_raddr_b_i), .fwd_valid(fwd_b_valid_o),
        .fwd_data(fwd_b_data_o), .hazard(hazard_b_o)
    );

    a_resp_pending: assert property (@(posedge clk_i) disable iff (rst_i)
        lsu_resp_valid_i |-> lsu_pend_q);
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CW'(Depth));
    a_enq_free: assert property (@(posedge clk_i) disable iff (rst_i)
        enq |-> (!q_q[tail_q].valid || retire));

endmodule

// File: tb/tb_cve2_wb_queue.sv
// Bench for cve2_wb_queue: directed vector table plus
// randomized traffic against a queue-level reference model.
module tb_cve2_wb_queue;
    import cve2_pkg::*;

    localparam int D = 2;
    localparam wb_instr_type_e OT = WB_INSTR_OTHER;
    localparam wb_instr_type_e LD = WB_INSTR_LOAD;
    localparam wb_instr_type_e ST = WB_INSTR_STORE;

    logic clk, rst, en, cmp, cnt, we, rs, er;
    wb_instr_type_e ty;
    logic [31:0] pc, wd, ld;
    logic [4:0]  wa, ra, rb;
    logic        rdy, fva, fvb, hza, hzb, rwe, done, perf, perfc, ol, os;
    logic [31:0] fda, fdb, rwd, rpc;
    logic [4:0]  rwa;
    logic [$clog2(D):0] count;

    cve2_wb_queue #(.Depth(D), .ResetAll(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .en_wb_i(en),
        .instr_type_wb_i(ty), .pc_id_i(pc),
        .instr_is_compressed_id_i(cmp),
        .instr_perf_count_id_i(cnt),
        .rf_waddr_id_i(wa), .rf_wdata_id_i(wd), .rf_we_id_i(we),
        .ready_wb_o(rdy), .lsu_resp_valid_i(rs),
        .lsu_resp_err_i(er), .rf_wdata_lsu_i(ld),
        .rf_raddr_a_i(ra), .rf_raddr_b_i(rb),
        .fwd_a_valid_o(fva), .fwd_b_valid_o(fvb),
        .fwd_a_data_o(fda), .fwd_b_data_o(fdb),
        .hazard_a_o(hza), .hazard_b_o(hzb),
        .rf_waddr_wb_o(rwa), .rf_wdata_wb_o(rwd), .rf_we_wb_o(rwe),
        .pc_wb_o(rpc), .instr_done_wb_o(done),
        .perf_instr_ret_wb_o(perf),
        .perf_instr_ret_compressed_wb_o(perfc),
        .outstanding_load_wb_o(ol), .outstanding_store_wb_o(os),
        .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic rst, en; wb_instr_type_e ty; logic [4:0] wa; logic [31:0] wd;
        logic rs, er; logic [31:0] rd; logic [4:0] ra, rb;
        logic xwe; logic [4:0] xwa; logic [31:0] xwd; logic xdn, xpf;
        int xcnt; logic xrdy, xhz, xfv; logic [31:0] xfd;
        logic xfvb; logic [31:0] xfdb;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        wb_instr_type_e ty; logic we; logic [4:0] wa; logic [31:0] wd, pc;
        logic cmp, cnt, done, err;
    } ment_t;
    ment_t mq[$];
    ment_t eff[$];

    task automatic mfwd(input logic [4:0] a, output logic fv, output logic [31:0] fd, output logic hz);
        fv = 1'b0; fd = '0; hz = 1'b0;
        if (a != 5'd0) begin
            for (int i = eff.size() - 1; i >= 0; i--) begin
                if (eff[i].we && eff[i].wa == a) begin
                    if (eff[i].done) begin fv = 1'b1; fd = eff[i].wd; end
                    else hz = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        en = 0; ty = OT; wa = 0; wd = 0; we = 0; pc = 0; cmp = 0; cnt = 1;
        rs = 0; er = 0; ld = 0; ra = 0; rb = 0;
    endtask

    initial begin
        // rst en ty wa wd rs er rd ra rb | xwe xwa xwd dn pf cnt rdy hz fv fd fvb fdb
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,OT,5,'h11,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,OT,6,'h22,0,0,0,0,0, 1,5,'h11,1,1,1,1,0,0,0,0,0});
        vecs.push_back('{0,1,OT,7,'h33,0,0,0,0,0, 1,6,'h22,1,1,1,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 1,7,'h33,1,1,1,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,LD,8,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,OT,9,'h5,0,0,0,0,0, 0,0,0,0,0,1,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,8,9, 0,0,0,0,0,2,0,1,0,0,1,'h5});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 0,0,0,0,0,2,0,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,1,0,'hCAFE,8,0, 1,8,'hCAFE,1,1,2,1,0,1,'hCAFE,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 1,9,'h5,1,1,1,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,LD,10,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,1,1,'hDEAD,0,0, 0,0,0,1,0,1,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,OT,3,'h7,0,0,0,3,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,LD,3,0,0,0,0,3,0, 1,3,'h7,1,1,1,1,0,1,'h7,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,3,0, 0,0,0,0,0,1,1,1,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,1,0,'h9,3,0, 1,3,'h9,1,1,1,1,0,1,'h9,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,LD,1,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,OT,2,'h44,0,0,0,0,0, 0,0,0,0,0,1,1,0,0,0,0,0});
        vecs.push_back('{0,1,OT,4,'h66,1,0,'h55,0,0, 1,1,'h55,1,1,2,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 1,2,'h44,1,1,2,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 1,4,'h66,1,1,1,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,LD,11,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,1,LD,12,0,0,0,0,0,0, 0,0,0,0,0,1,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,12,0, 0,0,0,0,0,2,0,1,0,0,0,0});
        vecs.push_back('{1,0,OT,0,0,0,0,0,12,0, 0,0,0,0,0,0,1,0,0,0,0,0});
        vecs.push_back('{0,0,OT,0,0,0,0,0,12,0, 0,0,0,0,0,0,1,0,0,0,0,0});

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pc", rpc, 0);
        chk("rst_waddr", rwa, 0);
        chk("rst_wdata", rwd, 0);
        chk("rst_ol", ol, 0);
        chk("rst_os", os, 0);
        chk("rst_perfc", perfc, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            idle_inputs();
            rst = vecs[i].rst; en = vecs[i].en; ty = vecs[i].ty;
            wa = vecs[i].wa; wd = vecs[i].wd; we = vecs[i].en;
            pc = 32'h100 + 32'(i) * 4;
            rs = vecs[i].rs; er = vecs[i].er; ld = vecs[i].rd;
            ra = vecs[i].ra; rb = vecs[i].rb;
            @(negedge clk);
            chk($sformatf("v%0d_we", i), rwe, vecs[i].xwe);
            if (vecs[i].xwe) begin
                chk($sformatf("v%0d_waddr", i), rwa, vecs[i].xwa);
                chk($sformatf("v%0d_wdata", i), rwd, vecs[i].xwd);
            end
            chk($sformatf("v%0d_done", i), done, vecs[i].xdn);
            chk($sformatf("v%0d_perf", i), perf, vecs[i].xpf);
            chk($sformatf("v%0d_count", i), count, vecs[i].xcnt);
            chk($sformatf("v%0d_ready", i), rdy, vecs[i].xrdy);
            chk($sformatf("v%0d_hz_a", i), hza, vecs[i].xhz);
            chk($sformatf("v%0d_fv_a", i), fva, vecs[i].xfv);
            if (vecs[i].xfv) chk($sformatf("v%0d_fd_a", i), fda, vecs[i].xfd);
            chk($sformatf("v%0d_fv_b", i), fvb, vecs[i].xfvb);
            if (vecs[i].xfvb) chk($sformatf("v%0d_fd_b", i), fdb, vecs[i].xfdb);
            chk($sformatf("v%0d_hz_b", i), hzb, 0);
        end

        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic r, pend, ret, xfva, xhza, xfvb, xhzb, xol, xos;
            logic [31:0] xfda, xfdb;
            int tgt;
            @(posedge clk);
            #1;
            r = ($urandom_range(0, 399) == 0);
            rst = r;
            en = 1'($urandom_range(0, 1));
            ty = wb_instr_type_e'(2'($urandom_range(0, 2)));
            wa = 5'($urandom_range(0, 7));
            we = (ty == ST) ? 1'b0 : 1'($urandom_range(0, 1));
            wd = $urandom; pc = $urandom;
            cmp = 1'($urandom_range(0, 1)); cnt = 1'($urandom_range(0, 1));
            pend = 1'b0;
            foreach (mq[i]) if (mq[i].ty != OT && !mq[i].done) pend = 1'b1;
            rs = !r && pend && ($urandom_range(0, 2) == 0);
            er = ($urandom_range(0, 5) == 0);
            ld = $urandom;
            ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
            @(negedge clk);
            if (r) mq.delete();
            eff = mq;
            tgt = -1;
            foreach (eff[i]) if (tgt < 0 && eff[i].ty != OT && !eff[i].done) tgt = i;
            if (rs && tgt >= 0) begin
                eff[tgt].done = 1'b1;
                if (er) begin eff[tgt].err = 1'b1; eff[tgt].we = 1'b0; end
                else if (eff[tgt].ty == LD) eff[tgt].wd = ld;
            end
            ret = eff.size() > 0 && eff[0].done;
            xol = 1'b0; xos = 1'b0;
            foreach (mq[i]) begin
                if (mq[i].ty == LD) xol = 1'b1;
                if (mq[i].ty == ST) xos = 1'b1;
            end
            mfwd(ra, xfva, xfda, xhza);
            mfwd(rb, xfvb, xfdb, xhzb);
            chk("r_we", rwe, ret && eff[0].we && !eff[0].err);
            if (ret && eff[0].we && !eff[0].err) begin
                chk("r_waddr", rwa, eff[0].wa);
                chk("r_wdata", rwd, eff[0].wd);
            end
            chk("r_pc", rpc, eff.size() > 0 ? eff[0].pc : 32'd0);
            chk("r_done", done, ret);
            chk("r_perf", perf, ret && eff[0].cnt && !eff[0].err);
            chk("r_perfc", perfc, ret && eff[0].cnt && !eff[0].err && eff[0].cmp);
            chk("r_ol", ol, xol);
            chk("r_os", os, xos);
            chk("r_count", count, mq.size());
            chk("r_ready", rdy, mq.size() < D || ret);
            chk("r_fv_a", fva, xfva);
            if (xfva) chk("r_fd_a", fda, xfda);
            chk("r_hz_a", hza, xhza);
            chk("r_fv_b", fvb, xfvb);
            if (xfvb) chk("r_fd_b", fdb, xfdb);
            chk("r_hz_b", hzb, xhzb);
            if (!r && en && (mq.size() < D || ret)) begin
                if (ret) void'(eff.pop_front());
                eff.push_back('{ty, we, wa, wd, pc, cmp, cnt, ty == OT, 1'b0});
                mq = eff;
            end else begin
                if (ret) void'(eff.pop_front());
                mq = eff;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
